reg_hex_display: RTL and testbench

Time-multiplexed 4-digit hexadecimal seven-segment driver sitting directly downstream of the MIPS core's 32-bit register-2 debug output (REG2_OUT). It shows one selectable 16-bit half of the value on the board display. The value is captured once per scan frame so digits never tear mid-frame. All display outputs are registered, active-low and glitch-free.

---
 rtl/seg_display_pkg.sv | 15 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/reg_hex_display.sv | 114 +++++++++++
 tb/tb_reg_hex_display.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants for the multiplexed hex seven-segment display.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/reg_hex_display.sv
// Four-digit scanned hex display of one 16-bit half of a debug register word.
// The shown half is latched once per scan frame so a frame never mixes two values.
module reg_hex_display
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_SUPPRESS = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           Value,
  input  logic                  Half_Sel,
  input  logic                  Blank,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic                  Frame_Tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [15:0]   sh;
  logic          hs_sh;

  logic          digit_wrap;
  logic          frame_end;
  logic [3:0]    nibble;
  logic [6:0]    seg_lit;
  logic          lead_zero;
  logic          digit_off;
  logic [NUM_DIGITS-1:0] an_next;

  assign digit_wrap = (cnt == CNT_LAST);
  assign frame_end  = digit_wrap && (dig == 2'd3);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      dig <= 2'd0;
    end else if (digit_wrap) begin
      cnt <= '0;
      dig <= dig + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Capture on the last cycle of digit 3 so the next frame starts on fresh data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh    <= 16'h0000;
      hs_sh <= 1'b0;
    end else if (frame_end) begin
      sh    <= Half_Sel ? Value[31:16] : Value[15:0];
      hs_sh <= Half_Sel;
    end
  end

  always_comb begin
    nibble    = sh[3:0];
    lead_zero = 1'b0;
    case (dig)
      2'd1: begin
        nibble    = sh[7:4];
        lead_zero = (sh[15:4] == 12'h000);
      end
      2'd2: begin
        nibble    = sh[11:8];
        lead_zero = (sh[15:8] == 8'h00);
      end
      2'd3: begin
        nibble    = sh[15:12];
        lead_zero = (sh[15:12] == 4'h0);
      end
      default: begin
        nibble    = sh[3:0];
        lead_zero = 1'b0;
      end
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (seg_lit)
  );

  assign an_next   = ~(NUM_DIGITS'(1) << dig);
  assign digit_off = Blank || (LZ_SUPPRESS && lead_zero);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      AN         <= AN_OFF;
      SEG        <= SEG_OFF;
      DP         <= 1'b1;
      Frame_Tick <= 1'b0;
    end else begin
      Frame_Tick <= frame_end;
      if (digit_off) begin
        AN  <= AN_OFF;
        SEG <= SEG_OFF;
        DP  <= 1'b1;
      end else begin
        AN  <= an_next;
        SEG <= seg_lit;
        DP  <= !((dig == 2'd0) && hs_sh);
      end
    end
  end

endmodule

// File: tb/tb_reg_hex_display.sv
// Scoreboard bench for reg_hex_display: one instance without and one with
// leading-zero suppression, both checked every cycle against a frame-level model.
module tb_reg_hex_display;

  localparam int R     = 4;
  localparam int FRAME = 4 * R;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } out_t;

  typedef struct packed {
    out_t a;
    out_t b;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Value;
  logic        Half_Sel;
  logic        Blank;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, ft_a, ft_b;

  int vectors = 0;
  int miscompares = 0;

  exp_t q[$];

  int          n_m;
  logic [15:0] sh_m;
  logic        hs_m;

  always #5 CLK = ~CLK;

  reg_hex_display #(.REFRESH_DIV(R), .LZ_SUPPRESS(1'b0)) u_dut (
    .CLK(CLK), .RST(RST), .Value(Value), .Half_Sel(Half_Sel), .Blank(Blank),
    .AN(an_a), .SEG(seg_a), .DP(dp_a), .Frame_Tick(ft_a)
  );

  reg_hex_display #(.REFRESH_DIV(R), .LZ_SUPPRESS(1'b1)) u_dut_lz (
    .CLK(CLK), .RST(RST), .Value(Value), .Half_Sel(Half_Sel), .Blank(Blank),
    .AN(an_b), .SEG(seg_b), .DP(dp_b), .Frame_Tick(ft_b)
  );

  // n = cycles since reset release; the digit on show and frame boundaries follow from it.
  function automatic out_t predict(input int n, input logic [15:0] sh, input logic hs,
                                   input logic blank, input bit lz);
    out_t o;
    int   d;
    logic [15:0] upper;
    d     = (n / R) % 4;
    upper = sh >> (4 * d);
    o.ft  = ((n % FRAME) == FRAME - 1);
    if (blank || (lz && d > 0 && upper == 16'h0)) begin
      o.an  = 4'hF;
      o.seg = 7'h7F;
      o.dp  = 1'b1;
    end else begin
      o.an    = 4'hF;
      o.an[d] = 1'b0;
      o.seg   = SEG_TBL[upper[3:0]];
      o.dp    = !(d == 0 && hs);
    end
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got an=%b seg=%h dp=%b ft=%b, expected an=%b seg=%h dp=%b ft=%b",
               name, $time, got.an, got.seg, got.dp, got.ft, exp.an, exp.seg, exp.dp, exp.ft);
    end
  endtask

  // Reference model: produces the expected outputs for the cycle after each edge.
  initial begin
    exp_t e;
    n_m  = 0;
    sh_m = 16'h0;
    hs_m = 1'b0;
    forever begin
      @(posedge CLK);
      if (RST) begin
        n_m  = 0;
        sh_m = 16'h0;
        hs_m = 1'b0;
      end else begin
        e.a = predict(n_m, sh_m, hs_m, Blank, 1'b0);
        e.b = predict(n_m, sh_m, hs_m, Blank, 1'b1);
        q.push_back(e);
        if ((n_m % FRAME) == FRAME - 1) begin
          sh_m = Half_Sel ? Value[31:16] : Value[15:0];
          hs_m = Half_Sel;
        end
        n_m++;
      end
    end
  end

  // Monitor: compares DUT outputs against the queued expectations away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && q.size() > 0) begin
        e = q.pop_front();
        check("scan", {an_a, seg_a, dp_a, ft_a}, e.a);
        check("scan_lz", {an_b, seg_b, dp_b, ft_b}, e.b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge CLK);
  endtask

  initial begin
    int   k;
    out_t rst_exp;
    rst_exp = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};

    RST = 1'b1; Value = 32'h0; Half_Sel = 1'b0; Blank = 1'b0;
    cycles(3);
    RST = 1'b0;
    Value = 32'hA5C3_9E71;
    Half_Sel = 1'b1;
    cycles(22);

    // Asynchronous reset mid-scan must take effect before the next edge.
    @(posedge CLK);
    #2;
    RST = 1'b1;
    q.delete();
    #1;
    check("reset_async", {an_a, seg_a, dp_a, ft_a}, rst_exp);
    check("reset_async_lz", {an_b, seg_b, dp_b, ft_b}, rst_exp);
    cycles(2);
    check("reset_held", {an_a, seg_a, dp_a, ft_a}, rst_exp);
    RST = 1'b0;

    k = 0;
    while (!ft_a && k < 40) begin
      @(negedge CLK);
      k++;
    end
    vectors++;
    if (k != FRAME) begin
      miscompares++;
      $display("FAIL first_tick: got %0d cycles, expected %0d", k, FRAME);
    end

    Value = 32'hDEAD_1234; Half_Sel = 1'b0;
    cycles(2 * FRAME);
    Half_Sel = 1'b1;
    cycles(2 * FRAME);
    Half_Sel = 1'b0;
    cycles(FRAME + 6);
    Value = 32'h0000_FFFF;
    cycles(FRAME + 10);
    Value = 32'h0000_0030;
    cycles(2 * FRAME + 3);
    Blank = 1'b1;
    cycles(FRAME + 5);
    Blank = 1'b0;
    cycles(FRAME);

    for (int i = 0; i < 60; i++) begin
      Value = $urandom;
      if ($urandom_range(0, 2) == 0) Value = Value >> $urandom_range(8, 31);
      Half_Sel = 1'($urandom_range(0, 1));
      Blank = ($urandom_range(0, 7) == 0);
      cycles($urandom_range(1, 12));
    end
    Blank = 1'b0;
    cycles(FRAME + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
